irq_ctrl: RTL
=============

# irq_ctrl

Memory-mapped interrupt controller on the bridge's peripheral port, between the interrupt sources (Timer0 IRQ, Timer1 IRQ, external `interrupt`) and the CPU's hardware interrupt input. It latches source events, applies a per-source mask and a per-source level/edge mode, and picks the highest-priority pending source. It drives a single interrupt line to the CPU and runs a claim/end-of-interrupt handshake so one source is serviced at a time.

## Interface
- `N_SRC`, default 3: number of sources, 1..8. Bit 0 = Timer0, bit 1 = Timer1, bit 2 = external.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-low. All state clears on a rising `clk` edge while `reset`=0.
- `src_irq` in N_SRC: raw source requests.
- `addr` in 30: word address `[31:2]` from the bridge. Decoded offsets: 0x0 PEND, 0x4 MASK, 0x8 MODE, 0xC CLAIM, 0x10 EOI. Base is 0x7F30.
- `we` in 1: full-word write strobe, already qualified by the bridge's address decode.
- `din` in 32: write data.
- `dout` out 32: combinational read data for `addr`. Unused bits read 0; EOI and undecoded offsets read 0.
- `irq_out` out 1: registered interrupt request to the CPU.

## Operation
- **PEND[N_SRC-1:0]**
  - Edge-mode bit: set on a rising edge of `src_irq[i]` (previous-sample register resets to 0). Cleared by writing 1 to that bit (W1C) or by a successful claim.
  - Level-mode bit: registered copy of `src_irq[i]`. W1C and claim have no effect on it.
- **MASK**: read/write, reset 0. A source is eligible when `PEND & MASK` is 1.
- **MODE**: read/write, reset 0 (all sources level). 1 = edge.
- **CLAIM**
  - Read: `id+1` of the lowest-index eligible source, or 0 if none. Lowest index has highest priority.
  - Write: claims the source.
- **EOI**: write-only; ends service.
- **FSM states IDLE, PENDING, SERVICE**
  - IDLE → PENDING when any source is eligible.
  - PENDING → IDLE when no source is eligible, e.g. after a mask write or W1C.
  - PENDING → SERVICE on a CLAIM write where `din[3:0]` equals the current CLAIM value (non-zero). This records `active_id` and clears that source's PEND bit if it is edge mode.
  - CLAIM writes with a mismatched value, or in any other state, are ignored.
  - SERVICE → IDLE on an EOI write where `din[3:0]` equals `active_id`. Any other EOI write is ignored.
- **`irq_out`**: 1 exactly while the state is PENDING.
- **No nesting**: events keep latching into PEND during SERVICE, but `irq_out` stays 0 until EOI.
- **Simultaneous events**
  - Source rising edge in the same cycle as W1C of that bit: set wins.
  - Claim and a new edge on the same source in the same cycle: the bit stays set.
  - MASK/MODE write together with a state transition: the transition uses the pre-write values. The new values take effect next cycle.
- **Reset mid-operation**: a low `reset` in any state returns to IDLE. `irq_out` goes to 0 and PEND, MASK, MODE, `active_id` and the edge history go to 0.

## Timing
- **Reset values**: `irq_out`=0. `dout` is combinational and reads 0 for every register after reset.
- **Latency without sync**
  - `src_irq` high before edge k: PEND is visible after edge k, `irq_out`=1 after edge k+1.
  - CLAIM write at edge k: `irq_out`=0 after edge k.
  - EOI write at edge k: state is IDLE after edge k. If another source is eligible, `irq_out`=1 again after edge k+1.
- **Register writes**: take effect at the edge where `we`=1. Reads reflect the new value in the following cycle.

## Configuration
- **`IRQ_CTRL_IN_SYNC_EN`**
  - Defined: `src_irq` passes through a two-flop synchronizer, reset 0, before edge detection and the level copy. This adds exactly 2 cycles to source-to-PEND latency.
  - Undefined: `src_irq` is used directly, for same-clock sources only.

## Structure
- **Shared package `irq_ctrl_pkg`**
  - FSM state enum (IDLE, PENDING, SERVICE).
  - Register word offsets (0x0, 0x1, 0x2, 0x3, 0x4 on `addr[4:2]`).
  - Base address 0x7F30.
  - ID width, 4.
- **Sub-module `irq_prio_enc`**: combinational lowest-index-first encoder, N_SRC in, `id+1` out (0 = none). Used for CLAIM and the FSM.

## Test plan
- **Reset**: hold `reset`=0 3 cycles with `src_irq`=3'b111 → `irq_out`=0; PEND, MASK, MODE, CLAIM read 0.
- **Level source**: MASK=3'b011, `src_irq[1]`=1 → PEND=2 after 1 edge, `irq_out`=1 after 2 edges, CLAIM=2.
  - Write CLAIM=2 → `irq_out`=0.
  - Drop `src_irq[1]`, write EOI=2 → IDLE, `irq_out` stays 0.
- **Priority**: MODE=3'b111, MASK=3'b111, pulse `src_irq[2]` then `src_irq[0]` → CLAIM=1.
  - Claim 1, then EOI 1 → CLAIM=3, and `irq_out` reasserts one cycle after the EOI.
- **Bad handshake**: in PENDING with CLAIM=1, write CLAIM=2 → still PENDING, `irq_out`=1.
  - In SERVICE with `active_id`=1, write EOI=3 → still SERVICE.
- **Race**: edge on `src_irq[0]` in the same cycle as a W1C write of 1 to PEND → PEND[0]=1.
  - Clear MASK while PENDING → `irq_out`=0 next cycle.
- **Sync latency**: with `IRQ_CTRL_IN_SYNC_EN` defined, `src_irq[0]` high before edge k → PEND[0] visible after edge k+2, `irq_out` after edge k+3.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map
// and claim-ID width.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0]  OFF_PEND  = 3'h0;
  localparam logic [2:0]  OFF_MASK  = 3'h1;
  localparam logic [2:0]  OFF_MODE  = 3'h2;
  localparam logic [2:0]  OFF_CLAIM = 3'h3;
  localparam logic [2:0]  OFF_EOI   = 3'h4;
  localparam int          N_REGS    = 5;

  localparam logic [31:0] BASE_ADDR = 32'h0000_7F30;
  localparam int          ID_W      = 4;

  // Word offset of a bus word address relative to the block base.
  function automatic logic [29:0] word_off(input logic [29:0] addr);
    return addr - BASE_ADDR[31:2];
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Peripheral-port bus between the bridge (master) and the interrupt controller (slave).
interface irq_ctrl_if;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, we, din, input dout);
  modport slave  (input addr, we, din, output dout);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: returns id+1 of the first set request, 0 if none.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with per-source mask, level/edge mode and
// claim/EOI handshake. Define IRQ_CTRL_IN_SYNC_EN to add a 2-flop input synchronizer.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  irq_ctrl_if.slave        bus,
  output logic             irq_out
);

  logic [N_SRC-1:0] src_s;

`ifdef IRQ_CTRL_IN_SYNC_EN
  logic [N_SRC-1:0] sync_p0;
  logic [N_SRC-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= src_irq;
      sync_p1 <= sync_p0;
    end
  end

  assign src_s = sync_p1;
`else
  assign src_s = src_irq;
`endif

  state_t           state;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] src_prev;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic [ID_W-1:0]  claim_id;
  logic [ID_W-1:0]  active_id;

  logic [29:0] off_full;
  logic        hit;
  logic [2:0]  off;
  logic        wr_pend, wr_mask, wr_mode, wr_claim, wr_eoi;
  logic        claim_ok, eoi_ok;

  assign off_full = word_off(bus.addr);
  assign hit      = (off_full < 30'(N_REGS));
  assign off      = off_full[2:0];

  assign wr_pend  = bus.we && hit && (off == OFF_PEND);
  assign wr_mask  = bus.we && hit && (off == OFF_MASK);
  assign wr_mode  = bus.we && hit && (off == OFF_MODE);
  assign wr_claim = bus.we && hit && (off == OFF_CLAIM);
  assign wr_eoi   = bus.we && hit && (off == OFF_EOI);

  assign eligible = pend & mask;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req (eligible),
    .id  (claim_id)
  );

  assign claim_ok = wr_claim && (state == ST_PENDING) && (claim_id != '0) &&
                    (bus.din[ID_W-1:0] == claim_id);
  assign eoi_ok   = wr_eoi && (state == ST_SERVICE) &&
                    (bus.din[ID_W-1:0] == active_id);

  assign rise = src_s & ~src_prev;
  assign w1c  = wr_pend ? bus.din[N_SRC-1:0] : '0;

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_clr[i] = claim_ok && (claim_id == ID_W'(i + 1));
    end
  end

  // Edge bits: a fresh rising edge beats both W1C and claim in the same cycle.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode[i]) pend_nxt[i] = (pend[i] & ~w1c[i] & ~claim_clr[i]) | rise[i];
      else         pend_nxt[i] = src_s[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend     <= '0;
      mask     <= '0;
      mode     <= '0;
      src_prev <= '0;
    end else begin
      pend     <= pend_nxt;
      src_prev <= src_s;
      if (wr_mask) mask <= bus.din[N_SRC-1:0];
      if (wr_mode) mode <= bus.din[N_SRC-1:0];
    end
  end

  // irq_out is registered alongside the state so it is high exactly in PENDING.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      active_id <= '0;
      irq_out   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state   <= ST_PENDING;
            irq_out <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (claim_ok) begin
            state     <= ST_SERVICE;
            active_id <= claim_id;
            irq_out   <= 1'b0;
          end else if (!(|eligible)) begin
            state   <= ST_IDLE;
            irq_out <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (eoi_ok) begin
            state   <= ST_IDLE;
            irq_out <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.dout = '0;
    if (hit) begin
      case (off)
        OFF_PEND:  bus.dout = 32'(pend);
        OFF_MASK:  bus.dout = 32'(mask);
        OFF_MODE:  bus.dout = 32'(mode);
        OFF_CLAIM: bus.dout = 32'(claim_id);
        default:   bus.dout = '0;
      endcase
    end
  end

endmodule
